// File: rtl/mips_div_pkg.sv
// Shared definitions for the iterative MIPS divider: FSM encoding and
// latency/result constants used by the RTL and its bench.
package mips_div_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CNT_WIDTH  = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } div_state_t;

   // Cycles from the Start cycle (cycle 0) to the Done cycle.
   localparam int DIV_LATENCY = DEF_DATA_WIDTH + 2;

   localparam logic [DEF_DATA_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of quotient and remainder.
module div_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/div32_iterative.sv
// Radix-2 restoring divider: magnitudes are divided one bit per cycle, then
// quotient and remainder are sign-corrected in a final FIX cycle.
module div32_iterative
   import mips_div_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic                  Signed,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  Busy,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] Quotient,
   output logic [DATA_WIDTH-1:0] Remainder,
   output logic                  DivByZero,
   output logic [1:0]            dbg_state
);

   // Handshake: Start is a request accepted only in a cycle where Busy=0
   // (IDLE, including the Done cycle); Start while Busy=1 is dropped.
   // Done is a one-cycle completion strobe; results hold until the next Done.

   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

   div_state_t state;
   div_state_t state_nxt;

   logic start_ok;
   logic iter_en;
   logic fix_en;

   logic [CNT_WIDTH-1:0]  cnt;
   logic [DATA_WIDTH-1:0] rem;
   logic [DATA_WIDTH-1:0] dvd;
   logic [DATA_WIDTH-1:0] dvs;
   logic [DATA_WIDTH-1:0] a_raw;
   logic                  q_neg;
   logic                  r_neg;
   logic                  zero_div;

   logic [DATA_WIDTH-1:0] mag_a;
   logic [DATA_WIDTH-1:0] mag_b;
   logic [DATA_WIDTH-1:0] q_fixed;
   logic [DATA_WIDTH-1:0] r_fixed;

   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
   logic                  borrow;
   logic                  take;
   logic                  unused_diff_msb;

   div_sign_fix #(.WIDTH(DATA_WIDTH)) u_mag_a (
      .value  (A),
      .negate (Signed & A[DATA_WIDTH-1]),
      .result (mag_a)
   );

   div_sign_fix #(.WIDTH(DATA_WIDTH)) u_mag_b (
      .value  (B),
      .negate (Signed & B[DATA_WIDTH-1]),
      .result (mag_b)
   );

   div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_q (
      .value  (dvd),
      .negate (q_neg),
      .result (q_fixed)
   );

   div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_r (
      .value  (rem),
      .negate (r_neg),
      .result (r_fixed)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (cnt == LAST_ITER) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy     = 1'b0;
      start_ok = 1'b0;
      iter_en  = 1'b0;
      fix_en   = 1'b0;
      case (state)
         IDLE: start_ok = Start;
         RUN: begin
            Busy    = 1'b1;
            iter_en = 1'b1;
         end
         FIX: begin
            Busy   = 1'b1;
            fix_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

   // The trial subtract carries one extra bit so a magnitude of 2^(W-1)
   // shifted left still compares correctly against any divisor.
   always_comb begin
      shifted          = {rem, dvd[DATA_WIDTH-1]};
      {borrow, diff}   = {1'b0, shifted} - {2'b00, dvs};
      take             = ~borrow;
      unused_diff_msb  = diff[DATA_WIDTH];
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         a_raw     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         zero_div  <= 1'b0;
         Done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (start_ok) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= mag_a;
            dvs      <= mag_b;
            a_raw    <= A;
            q_neg    <= (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]) & Signed;
            r_neg    <= A[DATA_WIDTH-1] & Signed;
            zero_div <= (B == '0);
         end
         if (iter_en) begin
            rem <= take ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            dvd <= {dvd[DATA_WIDTH-2:0], take};
            cnt <= cnt + CNT_WIDTH'(1);
         end
         if (fix_en) begin
            // A zero divisor reports the raw dividend regardless of Signed.
            Quotient  <= zero_div ? {DATA_WIDTH{1'b1}} : q_fixed;
            Remainder <= zero_div ? a_raw : r_fixed;
            DivByZero <= zero_div;
            Done      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_div32_iterative.sv
// Bench for div32_iterative: directed MIPS DIV/DIVU cases, handshake and
// reset corners, then random operands against an arithmetic reference model.
module tb_div32_iterative;
   import mips_div_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          sgn = 1'b0;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] b = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] quot;
   logic [DW-1:0] rem;
   logic          dz;
   logic [1:0]    dbg_state;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   logic [64:0] exp_q[$];
   int          lat_q[$];

   div32_iterative dut (
      .Clk       (clk),
      .Rst       (rst),
      .Start     (start),
      .Signed    (sgn),
      .A         (a),
      .B         (b),
      .Busy      (busy),
      .Done      (done),
      .Quotient  (quot),
      .Remainder (rem),
      .DivByZero (dz),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division, truncating toward zero, remainder
   // takes the dividend's sign; zero divisor gives all-ones and raw A.
   function automatic logic [64:0] ref_div(input logic s, input logic [DW-1:0] x, input logic [DW-1:0] y);
      longint sx;
      longint sy;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      if (y == 0) return {1'b1, DIV_ZERO_QUOT, x};
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         q  = DW'(sx / sy);
         r  = DW'(sx % sy);
      end else begin
         q = x / y;
         r = x % y;
      end
      return {1'b0, q, r};
   endfunction

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return DW'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // driver: request accepted at the next rising edge; expectation queued then
   task automatic issue(input logic s, input logic [DW-1:0] x, input logic [DW-1:0] y);
      start = 1'b1;
      sgn   = s;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      exp_q.push_back(ref_div(s, x, y));
      lat_q.push_back(cyc + DIV_LATENCY - 1);
      start = 1'b0;
      sgn   = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   // driver: a Start expected to be dropped, so nothing is queued
   task automatic poke_start(input logic s, input logic [DW-1:0] x, input logic [DW-1:0] y);
      start = 1'b1;
      sgn   = s;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         n_chk++;
         n_err++;
         $display("FAIL %s_timeout: got no Done expected Done within 200 cycles", name);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_quot"},  quot, 0);
      check({tag, "_rem"},   rem, 0);
      check({tag, "_dz"},    dz, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [64:0] e;
      int          ec;
      if (rst && done) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done: got Done=1 expected no outstanding request (cycle %0d)", cyc);
         end else begin
            e  = exp_q.pop_front();
            ec = lat_q.pop_front();
            check("quotient",     quot, e[63:32]);
            check("remainder",    rem, e[31:0]);
            check("divbyzero",    dz, e[64]);
            check("latency",      cyc, ec);
            check("busy_in_done", busy, 0);
         end
      end
   end

   initial begin
      int gap;
      logic s;
      logic [DW-1:0] x;
      logic [DW-1:0] y;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;

      issue(1'b0, 32'd100, 32'd7);
      wait_done("unsigned");
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("signed");
      issue(1'b1, 32'h1234_5678, 32'h0);
      wait_done("zero_div");
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("overflow");

      // second Start while busy must be dropped
      issue(1'b0, 32'd1000, 32'd9);
      repeat (4) @(posedge clk);
      #1;
      check("busy_before_poke", busy, 1);
      poke_start(1'b1, 32'hDEAD_BEEF, 32'd3);
      wait_done("ignored_start");

      // Start in the Done cycle is accepted with no bubble
      issue(1'b1, 32'h8000_0001, 32'd5);
      wait_done("b2b_first");
      issue(1'b0, 32'hFFFF_FFFF, 32'h0001_0000);
      wait_done("b2b_second");

      // reset aborts an in-flight op: no Done afterwards
      issue(1'b0, 32'd555, 32'd11);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      check_reset_outputs("midop_reset");
      repeat (40) @(posedge clk);
      #1;
      issue(1'b1, 32'hFFFF_FF9C, 32'd7);
      wait_done("after_reset");

      // random operations, some back-to-back
      for (int n = 0; n < 200; n++) begin
         s = 1'($urandom);
         x = pick_operand();
         y = pick_operand();
         issue(s, x, y);
         wait_done("random");
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/div32_iterative.md
Name: div32_iterative

Overview:
Multi-cycle integer divider for the MIPS pipeline. It is the inverse partner of the single-cycle ALU multiply path: the EX stage issues DIV/DIVU operands with a start pulse, then stalls on Busy. The block returns quotient (LO) and remainder (HI) after a fixed latency, using radix-2 restoring division on magnitudes with a sign fix-up step.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous reset, active-low (asserted when 0, sampled on Clk rising edge)
Start  input  1  one-cycle request; accepted only when Busy=0
Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start
A  input  DATA_WIDTH  dividend, sampled with Start
B  input  DATA_WIDTH  divisor, sampled with Start
Busy  output  1  high while a division is in flight
Done  output  1  one-cycle pulse; results valid and stable from this cycle onward
Quotient  output  DATA_WIDTH  LO result, held until the next Done
Remainder  output  DATA_WIDTH  HI result, held until the next Done
DivByZero  output  1  flag for the last completed operation, held with the results

Behaviour:
- Reset (Rst=0 at an edge): state=IDLE; Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0. Reset aborts any in-flight operation; no Done is produced for it.
- States:
  - IDLE: on Start=1, latch the following: |A|, |B| (magnitudes if Signed, raw values otherwise), the quotient sign (A[msb]^B[msb])&Signed, the remainder sign A[msb]&Signed, and the zero-divisor flag. Clear the partial remainder, set the counter to 0, go to RUN.
  - RUN: each cycle shifts {rem,dividend} left by 1. Trial-subtract the divisor; if the difference is non-negative, keep it and set quotient bit = 1, else restore and set the bit to 0. Increment the counter. After iteration DATA_WIDTH, go to FIX.
  - FIX: negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set. Register Quotient, Remainder and DivByZero, pulse Done, go to IDLE.
- Timing: Start sampled at edge k gives the following:
  - Busy=1 after edge k through edge k+DATA_WIDTH+1.
  - Done=1 for exactly the cycle after edge k+DATA_WIDTH+1 (34-cycle latency at defaults).
  - Busy=0 in the Done cycle.
- Start while Busy=1 is ignored, with no queuing. Start in the Done cycle is accepted, so back-to-back operations run with no bubble.
- A, B and Signed are don't-care except in the Start cycle.
- Rounding: the quotient truncates toward zero, and the remainder takes the sign of the dividend (MIPS semantics).
- Divide by zero (B=0): run the full latency and set DivByZero=1. Results are forced to Quotient=all-ones and Remainder=A (original, unsigned view), regardless of Signed.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, Signed=1): Quotient=0x80000000, Remainder=0, DivByZero=0. This falls out of the magnitude path with no special case.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned. The subtractor is DATA_WIDTH+1 bits wide so the trial difference never overflows.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package mips_div_pkg holds the following:
  - state encoding typedef (IDLE=2'b00, RUN=2'b01, FIX=2'b10)
  - DIV_LATENCY constant (DATA_WIDTH+2)
  - DIV_ZERO_QUOT constant (all-ones)
- One natural sub-module, div_sign_fix: a combinational conditional two's-complement negate, instantiated for operand magnitude and for result fix-up.
- The iteration datapath stays in the top module.

Test Plan:
- Unsigned: A=100, B=7, Signed=0 -> Done at cycle 34 after Start; Quotient=14, Remainder=2, DivByZero=0.
- Signed: A=-7 (0xFFFFFFF9), B=2, Signed=1 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1).
- Zero divisor: A=0x12345678, B=0, Signed=1 -> Quotient=0xFFFFFFFF, Remainder=0x12345678, DivByZero=1.
- Overflow: A=0x80000000, B=0xFFFFFFFF, Signed=1 -> Quotient=0x80000000, Remainder=0.
- Handshake:
  - Second Start at cycle 5 of Busy with different operands -> ignored; results match the first request.
  - Start in the Done cycle -> accepted; next Done follows 34 cycles later.
- Reset mid-op: Rst=0 at cycle 10 of RUN -> next cycle Busy=0, Done=0, outputs 0; no Done appears afterwards; a new Start then completes normally.
